change_dispenser: RTL and testbench

- Return-coin path of the vending machine. It is the consumer of the return amount that the state-calculation block produces.
- Accepts a change amount through a valid/ready handshake and decomposes it greedily into coins, largest denomination first.
- Pulses one one-hot `o_return_coin` bit per coin toward the coin chute, then reports completion and any undispensable residue.

---
 rtl/change_dispenser_if.sv | 26 ++
 rtl/change_dispenser.sv | 143 ++++++++++++++
 tb/tb_change_dispenser.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// rtl/change_dispenser_if.sv - request, chute, status and stock signals of the change dispenser
interface change_dispenser_if #(
   parameter int NUM_COINS  = 3,
   parameter int TOTAL_BITS = 31
);
   logic                  i_req_valid;
   logic [TOTAL_BITS-1:0] i_req_amount;
   logic                  o_req_ready;
   logic                  i_chute_ready;
   logic [NUM_COINS-1:0]  o_return_coin;
   logic                  o_busy;
   logic                  o_done;
   logic [TOTAL_BITS-1:0] o_remainder;
   logic [NUM_COINS-1:0]  i_refill;
   logic [NUM_COINS-1:0]  o_coin_empty;

   modport master (
      output i_req_valid, i_req_amount, i_chute_ready, i_refill,
      input  o_req_ready, o_return_coin, o_busy, o_done, o_remainder, o_coin_empty
   );

   modport slave (
      input  i_req_valid, i_req_amount, i_chute_ready, i_refill,
      output o_req_ready, o_return_coin, o_busy, o_done, o_remainder, o_coin_empty
   );
endinterface

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy coin change dispenser; COIN_STOCK_EN adds per-coin stock counters
module change_dispenser #(
   parameter int NUM_COINS  = 3,
   parameter int TOTAL_BITS = 31,
   parameter int COIN0_VAL  = 100,
   parameter int COIN1_VAL  = 500,
   parameter int COIN2_VAL  = 1000,
   parameter int STOCK_BITS = 8,
   parameter int INIT_STOCK = 10
) (
   input  logic               clk,
   input  logic               reset,
   change_dispenser_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_DISPENSE, S_DONE} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [TOTAL_BITS-1:0] remaining;
   logic [NUM_COINS-1:0]  return_coin;
   logic [TOTAL_BITS-1:0] remainder;
   logic [NUM_COINS-1:0]  have_stock;
   logic [NUM_COINS-1:0]  sel_onehot;
   logic [TOTAL_BITS-1:0] sel_val;
   logic                  sel_valid;
   logic                  accept;
   logic                  fire;

   // Denominations beyond the three defined ones are never selectable.
   function automatic logic [TOTAL_BITS-1:0] coin_val(input int idx);
      case (idx)
         0:       return TOTAL_BITS'(COIN0_VAL);
         1:       return TOTAL_BITS'(COIN1_VAL);
         2:       return TOTAL_BITS'(COIN2_VAL);
         default: return '1;
      endcase
   endfunction

   assign accept    = (state == S_IDLE) && bus.i_req_valid;
   assign sel_valid = |sel_onehot;
   assign fire      = (state == S_DISPENSE) && sel_valid && bus.i_chute_ready;

   // Greedy pick: the highest-index coin that fits the remaining amount and is in stock.
   always_comb begin
      sel_onehot = '0;
      sel_val    = '0;
      for (int i = 0; i < NUM_COINS; i++) begin
         if (coin_val(i) <= remaining && have_stock[i]) begin
            sel_onehot    = '0;
            sel_onehot[i] = 1'b1;
            sel_val       = coin_val(i);
         end
      end
   end

`ifdef COIN_STOCK_EN
   logic [STOCK_BITS-1:0] stock [NUM_COINS];

   // Per-coin stock: dispense decrements, refill increments saturating, both together cancel.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_COINS; i++) begin
         if (reset) begin
            stock[i] <= STOCK_BITS'(INIT_STOCK);
         end else if (fire && sel_onehot[i]) begin
            if (!bus.i_refill[i]) begin
               stock[i] <= stock[i] - 1'b1;
            end
         end else if (bus.i_refill[i] && stock[i] != {STOCK_BITS{1'b1}}) begin
            stock[i] <= stock[i] + 1'b1;
         end
      end
   end

   // Empty flags come straight from the counters.
   always_comb begin
      for (int i = 0; i < NUM_COINS; i++) begin
         have_stock[i]       = (stock[i] != '0);
         bus.o_coin_empty[i] = (stock[i] == '0);
      end
   end
`else
   logic                  unused_refill;
   logic [STOCK_BITS-1:0] unused_stock_init;

   assign unused_refill     = ^bus.i_refill;
   assign unused_stock_init = STOCK_BITS'(INIT_STOCK);
   assign have_stock        = '1;
   assign bus.o_coin_empty  = '0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: running out of selectable coins ends the dispense even while the chute stalls.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (accept) state_nxt = S_DISPENSE;
         S_DISPENSE: if (!sel_valid) state_nxt = S_DONE;
         S_DONE:     state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // Datapath: amount load, coin pulse and residue capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         remaining   <= '0;
         return_coin <= '0;
         remainder   <= '0;
      end else begin
         return_coin <= '0;
         if (accept) begin
            remaining <= bus.i_req_amount;
            remainder <= '0;
         end else if (state == S_DISPENSE) begin
            if (!sel_valid) begin
               remainder <= remaining;
            end else if (bus.i_chute_ready) begin
               return_coin <= sel_onehot;
               remaining   <= remaining - sel_val;
            end
         end
      end
   end

   // Status outputs decoded from the state.
   always_comb begin
      bus.o_req_ready   = (state == S_IDLE);
      bus.o_busy        = (state != S_IDLE);
      bus.o_done        = (state == S_DONE);
      bus.o_return_coin = return_coin;
      bus.o_remainder   = remainder;
   end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed vector bench for change_dispenser
module tb_change_dispenser;

   typedef struct {
      logic [30:0] amount;
      int          stall;
      int          n;
      logic [23:0] seq;
      logic [30:0] rem;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   vec_t vecs [6];

   change_dispenser_if #(.NUM_COINS(3), .TOTAL_BITS(31)) bus ();

   change_dispenser dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] seq5(input logic [2:0] a, b, c, d, e);
      return {9'b0, e, d, c, b, a};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic check_idle_outputs(input string name);
      chk({name, "_ready"},  32'(bus.o_req_ready),   1);
      chk({name, "_busy"},   32'(bus.o_busy),        0);
      chk({name, "_done"},   32'(bus.o_done),        0);
      chk({name, "_coin"},   32'(bus.o_return_coin), 0);
      chk({name, "_rem"},    32'(bus.o_remainder),   0);
   endtask

   // One request: stall cycles hold the chute low for the first DISPENSE edges.
   task automatic run_req(input logic [30:0] amount, input int stall, input int n,
                          input logic [23:0] seq, input logic [30:0] rem);
      logic [2:0] coins [8];
      int         ncoin;
      int         done_edge;
      logic       got_done;
      logic       busy_bad;
      ncoin     = 0;
      done_edge = 0;
      got_done  = 1'b0;
      busy_bad  = 1'b0;
      chk("ready_before", 32'(bus.o_req_ready), 1);
      bus.i_chute_ready = (stall == 0);
      bus.i_req_valid   = 1'b1;
      bus.i_req_amount  = amount;
      @(posedge clk);
      #1;
      bus.i_req_valid = 1'b0;
      for (int k = 1; k <= 64 && !got_done; k++) begin
         @(posedge clk);
         #1;
         if (k >= stall) bus.i_chute_ready = 1'b1;
         if (!bus.o_busy) busy_bad = 1'b1;
         if ($countones(bus.o_return_coin) > 1) busy_bad = 1'b1;
         if (bus.o_return_coin != 3'b000) begin
            if (ncoin < 8) coins[ncoin] = bus.o_return_coin;
            ncoin++;
         end
         if (bus.o_done) begin
            got_done  = 1'b1;
            done_edge = k;
            chk("remainder_at_done", 32'(bus.o_remainder), 32'(rem));
         end
      end
      chk("done_seen", 32'(got_done), 1);
      chk("done_edge", done_edge, n + 1 + stall);
      chk("busy_onehot_ok", 32'(busy_bad), 0);
      chk("ncoins", ncoin, n);
      for (int j = 0; j < n && j < ncoin && j < 8; j++) begin
         chk("coin", 32'(coins[j]), 32'(seq[3*j +: 3]));
      end
      @(posedge clk);
      #1;
      chk("done_one_cycle", 32'(bus.o_done), 0);
      chk("ready_after", 32'(bus.o_req_ready), 1);
      chk("busy_after", 32'(bus.o_busy), 0);
      chk("remainder_held", 32'(bus.o_remainder), 32'(rem));
   endtask

   initial begin
      vecs[0] = '{amount: 31'd1600, stall: 0, n: 3, seq: seq5(3'b100, 3'b010, 3'b001, 3'b000, 3'b000), rem: 31'd0};
      vecs[1] = '{amount: 31'd250,  stall: 0, n: 2, seq: seq5(3'b001, 3'b001, 3'b000, 3'b000, 3'b000), rem: 31'd50};
      vecs[2] = '{amount: 31'd0,    stall: 0, n: 0, seq: 24'd0, rem: 31'd0};
      vecs[3] = '{amount: 31'd1500, stall: 3, n: 2, seq: seq5(3'b100, 3'b010, 3'b000, 3'b000, 3'b000), rem: 31'd0};
      vecs[4] = '{amount: 31'd2700, stall: 0, n: 5, seq: seq5(3'b100, 3'b100, 3'b010, 3'b001, 3'b001), rem: 31'd0};
      vecs[5] = '{amount: 31'd99,   stall: 0, n: 0, seq: 24'd0, rem: 31'd99};

      reset             = 1'b1;
      bus.i_req_valid   = 1'b0;
      bus.i_req_amount  = '0;
      bus.i_chute_ready = 1'b1;
      bus.i_refill      = '0;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      chk("reset_empty", 32'(bus.o_coin_empty), 0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int v = 0; v < 6; v++) begin
         run_req(vecs[v].amount, vecs[v].stall, vecs[v].n, vecs[v].seq, vecs[v].rem);
      end

      // Reset in the middle of a 1600 request drops the dispense.
      bus.i_req_valid  = 1'b1;
      bus.i_req_amount = 31'd1600;
      @(posedge clk);
      #1;
      bus.i_req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_first_coin", 32'(bus.o_return_coin), 32'b100);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_idle_outputs("mid_reset");
      run_req(31'd500, 0, 1, seq5(3'b010, 3'b000, 3'b000, 3'b000, 3'b000), 31'd0);

`ifdef COIN_STOCK_EN
      for (int r = 0; r < 10; r++) begin
         run_req(31'd1000, 0, 1, seq5(3'b100, 3'b000, 3'b000, 3'b000, 3'b000), 31'd0);
      end
      run_req(31'd1000, 0, 2, seq5(3'b010, 3'b010, 3'b000, 3'b000, 3'b000), 31'd0);
      chk("coin2_empty", 32'(bus.o_coin_empty), 32'b100);
      bus.i_refill = 3'b100;
      @(posedge clk);
      #1;
      bus.i_refill = 3'b000;
      chk("coin2_refilled", 32'(bus.o_coin_empty), 0);
      run_req(31'd1000, 0, 1, seq5(3'b100, 3'b000, 3'b000, 3'b000, 3'b000), 31'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
